// File: rtl/sbox_scheduler.sv
// Shares a bank of LANES external S-boxes between the AES state (16 bytes) and key-schedule (4 bytes) requesters.
// Build option: define SBOX_SCHED_RR_EN for round-robin arbitration; otherwise the key port has fixed priority.
//
// state   | meaning
// IDLE    | no job; arbitrate and accept a new request
// RUN_ST  | streaming state bytes through the lanes, one chunk per cycle
// RUN_KEY | streaming key-word bytes through the lanes, one chunk per cycle
module sbox_scheduler #(
   parameter int LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 st_valid,
   input  logic [127:0]         st_in,
   output logic                 st_ready,
   output logic [127:0]         st_out,
   output logic                 st_done,
   input  logic                 key_valid,
   input  logic [31:0]          key_in,
   output logic                 key_ready,
   output logic [31:0]          key_out,
   output logic                 key_done,
   output logic [8*LANES-1:0]   sbox_in,
   input  logic [8*LANES-1:0]   sbox_out,
   output logic                 busy
);

   localparam int N_ST  = 16 / LANES;
   localparam int N_KEY = (LANES >= 4) ? 1 : 4 / LANES;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN_ST  = 2'd1,
      RUN_KEY = 2'd2
   } state_t;

   state_t       state_q;
   state_t       state_d;
   logic [3:0]   cnt_q;
   logic [127:0] op_q;
   logic         key_pri;
   logic         acc_st;
   logic         acc_key;
   logic         st_last;
   logic         key_last;
   logic [15:0]  st_hit;
   logic [3:0]   key_hit;
   logic [7:0]   st_byte  [16];
   logic [7:0]   key_byte [4];

`ifdef SBOX_SCHED_RR_EN
   logic last_key_q;

   // Pointer remembers who was served last; reset means "state served last".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_key_q <= 1'b0;
      end else if (acc_key) begin
         last_key_q <= 1'b1;
      end else if (acc_st) begin
         last_key_q <= 1'b0;
      end
   end

   assign key_pri = !last_key_q;
`else
   assign key_pri = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      key_ready = 1'b0;
      st_ready  = 1'b0;
      case (state_q)
         IDLE: begin
            // With no request pending the state port is the one left ready.
            key_ready = key_valid && (!st_valid || key_pri);
            st_ready  = !key_ready;
            if (key_valid && key_ready) begin
               state_d = RUN_KEY;
            end else if (st_valid && st_ready) begin
               state_d = RUN_ST;
            end
         end
         RUN_ST: begin
            if (cnt_q == 4'(N_ST - 1)) begin
               state_d = IDLE;
            end
         end
         RUN_KEY: begin
            if (cnt_q == 4'(N_KEY - 1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign acc_st   = st_valid && st_ready;
   assign acc_key  = key_valid && key_ready;
   assign st_last  = (state_q == RUN_ST)  && (cnt_q == 4'(N_ST - 1));
   assign key_last = (state_q == RUN_KEY) && (cnt_q == 4'(N_KEY - 1));
   assign busy     = (state_q != IDLE);

   // Key operands are zero-extended, so lanes past byte 3 of a key job see 0x00.
   always_comb begin
      sbox_in = '0;
      if (state_q != IDLE) begin
         for (int k = 0; k < N_ST; k++) begin
            if (cnt_q == 4'(k)) begin
               sbox_in = op_q[8*LANES*k +: 8*LANES];
            end
         end
      end
   end

   for (genvar b = 0; b < 16; b++) begin : g_st_map
      localparam int CH = b / LANES;
      localparam int LN = b % LANES;
      assign st_hit[b]  = (state_q == RUN_ST) && (cnt_q == 4'(CH));
      assign st_byte[b] = sbox_out[8*LN +: 8];
   end

   for (genvar b = 0; b < 4; b++) begin : g_key_map
      localparam int CH = b / LANES;
      localparam int LN = b % LANES;
      assign key_hit[b]  = (state_q == RUN_KEY) && (cnt_q == 4'(CH));
      assign key_byte[b] = sbox_out[8*LN +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         op_q     <= '0;
         st_out   <= '0;
         key_out  <= '0;
         st_done  <= 1'b0;
         key_done <= 1'b0;
      end else begin
         st_done  <= st_last;
         key_done <= key_last;
         if (acc_key) begin
            op_q  <= {96'd0, key_in};
            cnt_q <= '0;
         end else if (acc_st) begin
            op_q  <= st_in;
            cnt_q <= '0;
         end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + 4'd1;
         end
         for (int b = 0; b < 16; b++) begin
            if (st_hit[b]) begin
               st_out[8*b +: 8] <= st_byte[b];
            end
         end
         for (int b = 0; b < 4; b++) begin
            if (key_hit[b]) begin
               key_out[8*b +: 8] <= key_byte[b];
            end
         end
      end
   end

endmodule

// File: doc/sbox_scheduler.md
# sbox_scheduler

Time-multiplexes a bank of `LANES` combinational S-box instances between two requesters in the AES encryption core: the round datapath (SubBytes on a 128-bit state) and the key expansion (SubWord on a 32-bit word). Each requester hands over a whole word with a valid/ready handshake. The scheduler streams it through the shared S-boxes `LANES` bytes per cycle, assembles the substituted result, and signals completion with a one-cycle done pulse. The block sits between the round controller / key schedule and the S-box bank, which is instantiated outside and wired to the `sbox_*` ports.

## Interface
- `LANES`, default 4: number of S-box instances driven in parallel. Legal values are 1, 2 and 4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `st_valid` in 1: state job request.
- `st_in` in 128: state to substitute. Byte i is `st_in[8i+7:8i]`.
- `st_ready` out 1: state job accepted on `st_valid && st_ready` at a rising edge.
- `st_out` out 128: substituted state. Valid while `st_done` is high; held until the next state job is accepted.
- `st_done` out 1: one-cycle completion pulse for a state job.
- `key_valid`, `key_in` [31:0], `key_ready`, `key_out` [31:0], `key_done`: same protocol as the state port, for a 4-byte word.
- `sbox_in` out 8*LANES: lane j drives bits [8j+7:8j].
- `sbox_out` in 8*LANES: S-box results, combinational from `sbox_in`.
- `busy` out 1: high whenever the FSM is not IDLE.

## Operation
- FSM states are IDLE, RUN_ST and RUN_KEY.
  - Both ready outputs are forced low outside IDLE.
- Grant in IDLE, combinational:
  - Only one requester valid: that requester gets ready.
  - Both valid: the arbitration rule under Configuration decides.
  - Neither valid: the state port shows ready, the key port does not.
- Accept: the input word is captured into an operand register, a chunk counter `cnt` is cleared, and the FSM moves to RUN_ST or RUN_KEY.
- Chunk count N:
  - State job: N = 16/LANES.
  - Key job: N = max(1, 4/LANES).
- Per RUN cycle k (k = 0..N-1):
  - Lane j carries operand byte k*LANES+j on `sbox_in`.
  - At the rising edge, the matching `sbox_out` bytes are written into the result register at the same byte positions.
  - Lanes beyond byte 3 of a key job drive 0x00 and their results are discarded.
- After the edge that writes chunk N-1:
  - The FSM returns to IDLE.
  - The matching done output is high for exactly one cycle.
  - The matching result output updates in that same cycle.
- `sbox_in` is 0 in IDLE.
- The result registers are separate, so the key job never disturbs `st_out` and the state job never disturbs `key_out`.

## Timing
- Reset value of every registered output is 0: `st_out`, `key_out`, `st_done`, `key_done`, `busy`, `sbox_in`. The FSM resets to IDLE and the arbitration pointer resets to "state served last".
- Latency: handshake at edge E0, then the done output is high in the cycle after edge EN.
  - State job: 16, 8 or 4 cycles for LANES = 1, 2, 4.
  - Key job: 4, 2 or 1 cycles for LANES = 1, 2, 4.
- Back-to-back: a new job can be accepted in the same cycle that done is high, so throughput is one job per N+1 cycles.
- Valid deasserted after acceptance: ignored. Input changes after acceptance: ignored.
- Reset asserted mid-job: the job is aborted immediately, no done pulse is issued, and all outputs return to reset values.
- Requester protocol: a requester holds valid and its data stable until ready. The scheduler never drops a valid request.

## Configuration
- `SBOX_SCHED_RR_EN` defined: round-robin arbitration.
  - When both requesters are valid in IDLE, the requester not served last wins.
  - The pointer updates on every accept.
- `SBOX_SCHED_RR_EN` undefined: fixed priority.
  - The key port always wins when both are valid.
  - The pointer logic is not compiled.

## Test plan
The bench instantiates `LANES` reference S-box instances on the `sbox_*` ports. Each line below is stimulus, then required response.
- Single key job, LANES=4, `key_in`=32'hFF19_4E23:
  - `key_out`=32'h1666_2FD4_2F26… must not be used; the byte-exact value is 32'h16D42F26.
  - `key_done` one cycle after the accept edge, `busy` high for 1 cycle.
- Single state job, LANES=1, `st_in` bytes 0..15 = 00,23,56,A3,4E,19,FF,CC,DF,00…:
  - `st_out` bytes = 63,26,B1,0A,2F,D4,16,4B,9E,63….
  - `st_done` exactly 16 cycles after accept.
- Both valid in IDLE, held continuously:
  - Without the macro: grants are key, key, key….
  - With `SBOX_SCHED_RR_EN`: grants alternate key, state, key, state, and `st_out`/`key_out` stay uncorrupted.
- Back-to-back state jobs, LANES=2: the second is accepted in the `st_done` cycle of the first, and its `st_done` follows 8 cycles later.
- `rst_n` pulsed low at cycle 3 of a LANES=1 state job: no `st_done`, `st_out`=0, `busy`=0, and a subsequent job completes correctly.
- `st_in` changed after accept: `st_out` reflects the captured value only.
